// File: rtl/alu_unit.sv
// Single-cycle RV32I integer execution unit behind the reservation station.
// Ports: clk/rst/rdy/rollback control, issue bundle in_*, CDB broadcast out_*.
module alu_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic        in_config,
  input  logic [31:0] in_value_1,
  input  logic [31:0] in_value_2,
  input  logic [31:0] in_value_pc,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_precise,
  input  logic        in_more_precise,
  input  logic [31:0] in_imm,
  input  logic [3:0]  in_rob_entry,
  output logic        out_config,
  output logic [31:0] out_val,
  output logic [3:0]  out_rob_entry,
  output logic        out_jump,
  output logic [31:0] out_target
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [31:0] val;
    logic        jump;
    logic [31:0] target;
  } ex_res_t;

  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_jalr;
  logic is_br;
  logic is_opi;
  logic is_op;

  always_comb begin
    is_lui   = (in_opcode == OPC_LUI);
    is_auipc = (in_opcode == OPC_AUIPC);
    is_jal   = (in_opcode == OPC_JAL);
    is_jalr  = (in_opcode == OPC_JALR);
    is_br    = (in_opcode == OPC_BR);
    is_opi   = (in_opcode == OPC_OPI);
    is_op    = (in_opcode == OPC_OP);
  end

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        is_sub;

  assign op_a   = in_value_1;
  assign op_b   = is_op ? in_value_2 : in_imm;
  assign shamt  = op_b[4:0];
  // SUB exists only in the register form; OP-IMM 000 is always ADDI.
  assign is_sub = is_op & in_more_precise & (in_precise == F3_ADD);

  logic [31:0] b_eff;
  logic [31:0] sum;

  assign b_eff = is_sub ? ~op_b : op_b;
  assign sum   = op_a + b_eff + {31'd0, is_sub};

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;

  function automatic logic [31:0] bit_rev(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

  // One right shifter serves all three shifts; SLL reverses in and out.
  logic        is_sll;
  logic        fill;
  logic [31:0] sh_src;
  logic [31:0] sh_raw;
  logic [31:0] sh_mask;
  logic [31:0] sh_out;

  assign is_sll  = (in_precise == F3_SLL);
  assign fill    = ~is_sll & in_more_precise & op_a[31];
  assign sh_src  = is_sll ? bit_rev(op_a) : op_a;
  assign sh_mask = ~(32'hFFFF_FFFF >> shamt);
  assign sh_raw  = (sh_src >> shamt) | (fill ? sh_mask : 32'd0);
  assign sh_out  = is_sll ? bit_rev(sh_raw) : sh_raw;

  logic [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    unique case (in_precise)
      F3_ADD:  alu_res = sum;
      F3_SLL:  alu_res = sh_out;
      F3_SLT:  alu_res = {31'd0, lt_s};
      F3_SLTU: alu_res = {31'd0, lt_u};
      F3_XOR:  alu_res = op_a ^ op_b;
      F3_SR:   alu_res = sh_out;
      F3_OR:   alu_res = op_a | op_b;
      F3_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  logic br_eq;
  logic br_lt;
  logic br_ltu;
  logic br_taken;

  assign br_eq  = (in_value_1 == in_value_2);
  assign br_lt  = $signed(in_value_1) < $signed(in_value_2);
  assign br_ltu = in_value_1 < in_value_2;

  always_comb begin
    br_taken = 1'b0;
    unique case (in_precise)
      F3_BEQ:  br_taken = br_eq;
      F3_BNE:  br_taken = ~br_eq;
      F3_BLT:  br_taken = br_lt;
      F3_BGE:  br_taken = ~br_lt;
      F3_BLTU: br_taken = br_ltu;
      F3_BGEU: br_taken = ~br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_imm;
  logic [31:0] jalr_sum;
  logic [31:0] jalr_tgt;

  assign pc_plus4    = in_value_pc + 32'd4;
  assign pc_plus_imm = in_value_pc + in_imm;
  assign jalr_sum    = in_value_1 + in_imm;
  assign jalr_tgt    = {jalr_sum[31:1], 1'b0};

  ex_res_t res;

  always_comb begin
    res.val    = '0;
    res.jump   = 1'b0;
    res.target = pc_plus4;
    unique case (1'b1)
      is_lui: begin
        res.val = in_imm;
      end
      is_auipc: begin
        res.val = pc_plus_imm;
      end
      is_jal: begin
        res.val    = pc_plus4;
        res.jump   = 1'b1;
        res.target = pc_plus_imm;
      end
      is_jalr: begin
        res.val    = pc_plus4;
        res.jump   = 1'b1;
        res.target = jalr_tgt;
      end
      is_br: begin
        res.jump   = br_taken;
        res.target = br_taken ? pc_plus_imm : pc_plus4;
      end
      is_opi, is_op: begin
        res.val = alu_res;
      end
      default: begin
        res.val = '0;
      end
    endcase
  end

  // Flush wins over stall and issue; idle cycles only drop the valid.
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      out_config    <= 1'b0;
      out_val       <= '0;
      out_rob_entry <= '0;
      out_jump      <= 1'b0;
      out_target    <= '0;
    end else if (rdy) begin
      out_config <= in_config;
      if (in_config) begin
        out_val       <= res.val;
        out_rob_entry <= in_rob_entry;
        out_jump      <= res.jump;
        out_target    <= res.target;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        in_config;
  logic [31:0] in_value_1;
  logic [31:0] in_value_2;
  logic [31:0] in_value_pc;
  logic [6:0]  in_opcode;
  logic [2:0]  in_precise;
  logic        in_more_precise;
  logic [31:0] in_imm;
  logic [3:0]  in_rob_entry;
  logic        out_config;
  logic [31:0] out_val;
  logic [3:0]  out_rob_entry;
  logic        out_jump;
  logic [31:0] out_target;

  int checks = 0;
  int errors = 0;

  alu_unit dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .rollback(rollback),
    .in_config(in_config),
    .in_value_1(in_value_1),
    .in_value_2(in_value_2),
    .in_value_pc(in_value_pc),
    .in_opcode(in_opcode),
    .in_precise(in_precise),
    .in_more_precise(in_more_precise),
    .in_imm(in_imm),
    .in_rob_entry(in_rob_entry),
    .out_config(out_config),
    .out_val(out_val),
    .out_rob_entry(out_rob_entry),
    .out_jump(out_jump),
    .out_target(out_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {jump, target, val}.
  function automatic logic [64:0] ref_exec(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        m,
    input logic [31:0] v1,
    input logic [31:0] v2,
    input logic [31:0] pc,
    input logic [31:0] imm
  );
    logic [31:0] v;
    logic [31:0] t;
    logic [31:0] b;
    logic        j;
    logic        tk;
    v = 0;
    t = pc + 4;
    j = 0;
    tk = 0;
    case (op)
      7'b0110111: v = imm;
      7'b0010111: v = pc + imm;
      7'b1101111: begin v = pc + 4; j = 1; t = pc + imm; end
      7'b1100111: begin v = pc + 4; j = 1; t = (v1 + imm) & 32'hFFFF_FFFE; end
      7'b1100011: begin
        case (f3)
          3'd0: tk = (v1 == v2);
          3'd1: tk = (v1 != v2);
          3'd4: tk = ($signed(v1) < $signed(v2));
          3'd5: tk = ($signed(v1) >= $signed(v2));
          3'd6: tk = (v1 < v2);
          3'd7: tk = (v1 >= v2);
          default: tk = 0;
        endcase
        if (tk) begin j = 1; t = pc + imm; end
      end
      7'b0010011, 7'b0110011: begin
        b = (op == 7'b0110011) ? v2 : imm;
        case (f3)
          3'd0: v = (op == 7'b0110011 && m) ? v1 - b : v1 + b;
          3'd1: v = v1 << b[4:0];
          3'd2: v = ($signed(v1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: v = (v1 < b) ? 32'd1 : 32'd0;
          3'd4: v = v1 ^ b;
          3'd5: begin
            if (m) v = $signed(v1) >>> b[4:0];
            else   v = v1 >> b[4:0];
          end
          3'd6: v = v1 | b;
          default: v = v1 & b;
        endcase
      end
      default: v = 0;
    endcase
    return {j, t, v};
  endfunction

  logic        exp_valid = 0;
  logic        exp_known = 0;
  logic        exp_cfg;
  logic [31:0] exp_val;
  logic [3:0]  exp_tag;
  logic        exp_jump;
  logic [31:0] exp_tgt;

  always @(posedge clk) begin
    logic [64:0] r;
    if (rst || rollback) begin
      exp_valid = 1;
      exp_known = 1;
      exp_cfg = 0;
      exp_val = 0;
      exp_tag = 0;
      exp_jump = 0;
      exp_tgt = 0;
    end else if (rdy) begin
      if (in_config) begin
        r = ref_exec(in_opcode, in_precise, in_more_precise,
                     in_value_1, in_value_2, in_value_pc, in_imm);
        exp_cfg = 1;
        exp_known = 1;
        exp_val = r[31:0];
        exp_tgt = r[63:32];
        exp_jump = r[64];
        exp_tag = in_rob_entry;
      end else begin
        exp_cfg = 0;
        exp_known = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (out_config !== exp_cfg) begin
        errors++;
        $display("FAIL model_cfg t=%0t got %0b want %0b",
                 $time, out_config, exp_cfg);
      end
      if (exp_known) begin
        checks++;
        if (out_val !== exp_val || out_rob_entry !== exp_tag ||
            out_jump !== exp_jump || out_target !== exp_tgt) begin
          errors++;
          $display("FAIL model_out t=%0t got v=%h g=%0d j=%0b t=%h want v=%h g=%0d j=%0b t=%h",
                   $time, out_val, out_rob_entry, out_jump, out_target,
                   exp_val, exp_tag, exp_jump, exp_tgt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic        m,
    input logic [31:0] v1,
    input logic [31:0] v2,
    input logic [31:0] pc,
    input logic [31:0] imm,
    input logic [3:0]  tag
  );
    in_config = 1;
    in_opcode = op;
    in_precise = f3;
    in_more_precise = m;
    in_value_1 = v1;
    in_value_2 = v2;
    in_value_pc = pc;
    in_imm = imm;
    in_rob_entry = tag;
  endtask

  task automatic idle();
    in_config = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] AUI = 7'b0010111;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] OP  = 7'b0110011;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops [9];
    logic [31:0] a;
    logic [31:0] b;
    ops[0] = LUI; ops[1] = AUI; ops[2] = JAL;
    ops[3] = JLR; ops[4] = BR;  ops[5] = OPI;
    ops[6] = OP;  ops[7] = BR;  ops[8] = OP;

    rst = 1; rdy = 1; rollback = 0;
    issue(OP, 3'd0, 0, 32'd7, 32'd5, 32'h0, 32'h0, 4'd9);
    tick();
    chk("rst_cfg", {31'd0, out_config}, 0);
    chk("rst_val", out_val, 0);
    chk("rst_tag", {28'd0, out_rob_entry}, 0);
    chk("rst_jmp", {31'd0, out_jump}, 0);
    chk("rst_tgt", out_target, 0);
    rst = 0;
    idle();
    tick();
    chk("post_rst_cfg", {31'd0, out_config}, 0);

    issue(OP, 3'd0, 0, 32'd7, 32'd5, 32'h0, 32'h0, 4'd3);
    tick();
    issue(OP, 3'd0, 1, 32'd5, 32'd7, 32'h0, 32'h0, 4'd4);
    chk("add_cfg", {31'd0, out_config}, 1);
    chk("add_val", out_val, 32'd12);
    chk("add_tag", {28'd0, out_rob_entry}, 3);
    tick();
    issue(OP, 3'd5, 1, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 4'd5);
    chk("sub_val", out_val, 32'hFFFF_FFFE);
    chk("sub_tag", {28'd0, out_rob_entry}, 4);
    tick();
    issue(OP, 3'd3, 0, 32'd1, 32'd1, 32'h0, 32'h0, 4'd6);
    chk("sra_val", out_val, 32'hF800_0000);
    chk("sra_tag", {28'd0, out_rob_entry}, 5);
    tick();
    idle();
    chk("sltu_cfg", {31'd0, out_config}, 1);
    chk("sltu_val", out_val, 0);
    chk("sltu_tag", {28'd0, out_rob_entry}, 6);
    tick();
    chk("idle_cfg", {31'd0, out_config}, 0);

    issue(BR, 3'd4, 0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd1);
    tick();
    chk("blt_jmp", {31'd0, out_jump}, 1);
    chk("blt_tgt", out_target, 32'h120);
    chk("blt_val", out_val, 0);
    issue(BR, 3'd6, 0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 4'd2);
    tick();
    chk("bltu_jmp", {31'd0, out_jump}, 0);
    chk("bltu_tgt", out_target, 32'h104);
    issue(BR, 3'd5, 0, 32'd3, 32'd3, 32'h100, 32'h20, 4'd3);
    tick();
    chk("bge_jmp", {31'd0, out_jump}, 1);

    issue(JAL, 3'd0, 0, 32'd0, 32'd0, 32'h200, 32'hFFFF_FFF8, 4'd4);
    tick();
    chk("jal_val", out_val, 32'h204);
    chk("jal_tgt", out_target, 32'h1F8);
    chk("jal_jmp", {31'd0, out_jump}, 1);
    issue(JLR, 3'd0, 0, 32'h1001, 32'd0, 32'h300, 32'h10, 4'd5);
    tick();
    chk("jalr_tgt", out_target, 32'h1010);
    chk("jalr_val", out_val, 32'h304);

    rdy = 0;
    issue(OPI, 3'd0, 0, 32'd1, 32'd0, 32'h400, 32'd2, 4'd7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_val", out_val, 32'h304);
      chk("stall_tag", {28'd0, out_rob_entry}, 5);
    end
    rdy = 1;
    tick();
    idle();
    chk("addi_cfg", {31'd0, out_config}, 1);
    chk("addi_val", out_val, 32'd3);
    chk("addi_tag", {28'd0, out_rob_entry}, 7);
    rdy = 0;
    tick();
    chk("hold_cfg", {31'd0, out_config}, 1);
    chk("hold_val", out_val, 32'd3);
    tick();
    rdy = 1;
    tick();
    chk("unstall_cfg", {31'd0, out_config}, 0);

    rollback = 1;
    issue(LUI, 3'd0, 0, 32'd0, 32'd0, 32'h500, 32'h1234_5000, 4'd8);
    tick();
    chk("rb_cfg", {31'd0, out_config}, 0);
    chk("rb_val", out_val, 0);
    rollback = 0;
    issue(LUI, 3'd0, 0, 32'd0, 32'd0, 32'h500, 32'h1234_5000, 4'd9);
    tick();
    idle();
    chk("lui_cfg", {31'd0, out_config}, 1);
    chk("lui_val", out_val, 32'h1234_5000);
    chk("lui_tgt", out_target, 32'h504);
    chk("lui_tag", {28'd0, out_rob_entry}, 9);

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      rollback = ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 99) < 85);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      issue(($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)],
            3'($urandom), 1'($urandom), a, b, $urandom, b,
            4'($urandom));
      in_config = ($urandom_range(0, 9) < 8);
      tick();
    end
    rst = 0; rollback = 0; rdy = 1;
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
